// File: rtl/rv32_dp_pkg.sv
// Shared widths and ALU/timer opcode encodings for the RV32I execution datapath.
package rv32_dp_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int DM_AW  = 5;

    // Register-register ops
    localparam logic [5:0] OP_ADD   = 6'b000001;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_SLL   = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_SLTU  = 6'b000101;
    localparam logic [5:0] OP_XOR   = 6'b000110;
    localparam logic [5:0] OP_SRL   = 6'b000111;
    localparam logic [5:0] OP_SRA   = 6'b001000;
    localparam logic [5:0] OP_OR    = 6'b001001;
    localparam logic [5:0] OP_AND   = 6'b001010;
    // Register-immediate ops
    localparam logic [5:0] OP_ADDI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_SLTIU = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_ORI   = 6'b001111;
    localparam logic [5:0] OP_ANDI  = 6'b010100;
    localparam logic [5:0] OP_SLLI  = 6'b010101;
    localparam logic [5:0] OP_SRLI  = 6'b010110;
    localparam logic [5:0] OP_SRAI  = 6'b010111;
    // Branch compares (result 1/0)
    localparam logic [5:0] OP_BEQ   = 6'b010000;
    localparam logic [5:0] OP_BNE   = 6'b010001;
    localparam logic [5:0] OP_BLT   = 6'b010010;
    localparam logic [5:0] OP_BGE   = 6'b010011;
    // Load address
    localparam logic [5:0] OP_LOAD  = 6'b011000;
    // Timer configuration
    localparam logic [5:0] OP_PSC_IMM = 6'b100001;
    localparam logic [5:0] OP_ARR_IMM = 6'b100010;
    localparam logic [5:0] OP_PSC_REG = 6'b100011;
    localparam logic [5:0] OP_ARR_REG = 6'b100100;

    // Sign-extend a 12-bit store offset to XLEN.
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv32_datapath_core_alu.sv
// Combinational ALU; unknown opcodes (including timer codes) produce zero.
module alu
    import rv32_dp_pkg::*;
(
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      shamt,
    output logic [XLEN-1:0] result
);

    // Opcode decode and datapath selection.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_SLL:   result = a << b[4:0];
            OP_SLT:   result = XLEN'($signed(a) < $signed(b));
            OP_SLTU:  result = XLEN'(a < b);
            OP_XOR:   result = a ^ b;
            OP_SRL:   result = a >> b[4:0];
            OP_SRA:   result = $signed(a) >>> b[4:0];
            OP_OR:    result = a | b;
            OP_AND:   result = a & b;
            OP_ADDI:  result = a + imm;
            OP_SLTI:  result = XLEN'($signed(a) < $signed(imm));
            OP_SLTIU: result = XLEN'(a < imm);
            OP_XORI:  result = a ^ imm;
            OP_ORI:   result = a | imm;
            OP_ANDI:  result = a & imm;
            OP_SLLI:  result = a << shamt;
            OP_SRLI:  result = a >> shamt;
            OP_SRAI:  result = $signed(a) >>> shamt;
            OP_BEQ:   result = XLEN'(a == b);
            OP_BNE:   result = XLEN'(a != b);
            OP_BLT:   result = XLEN'($signed(a) < $signed(b));
            OP_BGE:   result = XLEN'($signed(a) >= $signed(b));
            OP_LOAD:  result = a + imm;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32_datapath_core_data_memory.sv
// 32-word data memory: synchronous write, asynchronous read.
module data_memory
    import rv32_dp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [DM_AW-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [DM_AW-1:0] raddr,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] mem [2**DM_AW];

    // Synchronous clear on reset, otherwise store on we.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2**DM_AW; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rv32_datapath_core_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero.
module regfile
    import rv32_dp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              we,
    input  logic [XLEN-1:0]   wd,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2
);

    logic [XLEN-1:0] regs [2**REG_AW];

    // Synchronous clear on reset; writes to x0 are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else if (we && (rd != '0)) begin
            regs[rd] <= wd;
        end
    end

    assign rd1 = (rs1 == '0) ? '0 : regs[rs1];
    assign rd2 = (rs2 == '0) ? '0 : regs[rs2];

endmodule

// File: rtl/rv32_datapath_core.sv
// RV32I execution datapath: register file, ALU, data memory, write-back, branch flags, timer config.
module rv32_datapath_core
    import rv32_dp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] read_reg_num1,
    input  logic [REG_AW-1:0] read_reg_num2,
    input  logic [REG_AW-1:0] write_reg_num,
    input  logic              reg_write,
    input  logic [5:0]        alu_cntrl,
    input  logic [XLEN-1:0]   imm_val,
    input  logic [4:0]        shamt,
    input  logic [11:0]       offset,
    input  logic              mem_to_reg,
    input  logic              sw,
    input  logic              lui_cntrl,
    input  logic [XLEN-1:0]   imm_val_lui,
    input  logic              jump,
    input  logic [XLEN-1:0]   return_address,
    input  logic              beq_cntrl,
    input  logic              bneq_cntrl,
    input  logic              blt_cntrl,
    input  logic              bgeq_cntrl,
    output logic              beq,
    output logic              bneq,
    output logic              blt,
    output logic              bge,
    output logic [XLEN-1:0]   alu_result,
    output logic [15:0]       TIM_PSC,
    output logic [15:0]       TIM_ARR
);

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] store_addr;
    logic            alu_is_one;

    regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .rs1   (read_reg_num1),
        .rs2   (read_reg_num2),
        .rd    (write_reg_num),
        .we    (reg_write),
        .wd    (wb_data),
        .rd1   (rs1_data),
        .rd2   (rs2_data)
    );

    alu u_alu (
        .op     (alu_cntrl),
        .a      (rs1_data),
        .b      (rs2_data),
        .imm    (imm_val),
        .shamt  (shamt),
        .result (alu_result)
    );

    assign store_addr = rs1_data + sext12(offset);

    data_memory u_dmem (
        .clk   (clk),
        .reset (reset),
        .we    (sw),
        .waddr (store_addr[DM_AW-1:0]),
        .wdata (rs2_data),
        .raddr (alu_result[DM_AW-1:0]),
        .rdata (mem_rdata)
    );

    // Write-back source select: jump > lui > load > ALU.
    always_comb begin
        wb_data = alu_result;
        if (jump)            wb_data = return_address;
        else if (lui_cntrl)  wb_data = imm_val_lui;
        else if (mem_to_reg) wb_data = mem_rdata;
    end

    assign alu_is_one = (alu_result == XLEN'(1));
    assign beq  = alu_is_one & beq_cntrl;
    assign bneq = alu_is_one & bneq_cntrl;
    assign blt  = alu_is_one & blt_cntrl;
    assign bge  = alu_is_one & bgeq_cntrl;

    // Timer prescaler / auto-reload registers, loaded by the timer opcodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            TIM_PSC <= '0;
            TIM_ARR <= '0;
        end else begin
            case (alu_cntrl)
                OP_PSC_IMM: TIM_PSC <= {imm_val[11:0], read_reg_num1[4:1]};
                OP_PSC_REG: TIM_PSC <= rs1_data[15:0];
                OP_ARR_IMM: TIM_ARR <= {imm_val[11:0], read_reg_num1[4:1]};
                OP_ARR_REG: TIM_ARR <= rs1_data[15:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_datapath_core.sv
// Scoreboard bench for rv32_datapath_core: directed test-plan steps plus randomized instructions.
module tb_rv32_datapath_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_n, rs2_n, rd_n;
    logic        reg_write;
    logic [5:0]  op;
    logic [31:0] imm_val;
    logic [4:0]  shamt;
    logic [11:0] offset;
    logic        mem_to_reg, sw, lui_cntrl, jump;
    logic [31:0] imm_val_lui, return_address;
    logic        beq_c, bneq_c, blt_c, bge_c;
    logic        beq, bneq, blt, bge;
    logic [31:0] alu_result;
    logic [15:0] tim_psc, tim_arr;

    always #5 clk = ~clk;

    rv32_datapath_core dut (
        .clk            (clk),
        .reset          (reset),
        .read_reg_num1  (rs1_n),
        .read_reg_num2  (rs2_n),
        .write_reg_num  (rd_n),
        .reg_write      (reg_write),
        .alu_cntrl      (op),
        .imm_val        (imm_val),
        .shamt          (shamt),
        .offset         (offset),
        .mem_to_reg     (mem_to_reg),
        .sw             (sw),
        .lui_cntrl      (lui_cntrl),
        .imm_val_lui    (imm_val_lui),
        .jump           (jump),
        .return_address (return_address),
        .beq_cntrl      (beq_c),
        .bneq_cntrl     (bneq_c),
        .blt_cntrl      (blt_c),
        .bgeq_cntrl     (bge_c),
        .beq            (beq),
        .bneq           (bneq),
        .blt            (blt),
        .bge            (bge),
        .alu_result     (alu_result),
        .TIM_PSC        (tim_psc),
        .TIM_ARR        (tim_arr)
    );

    // Reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [32];
    logic [15:0] m_psc, m_arr;

    typedef struct {
        int          kind;   // 0 alu,1 beq,2 bneq,3 blt,4 bge,5 psc,6 arr
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    function automatic void push(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind; e.exp = exp; e.name = name;
        sb.push_back(e);
    endfunction

    // Reference ALU straight from the opcode table
    function automatic logic [31:0] ref_alu(input logic [5:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm,
                                            input logic [4:0] sh);
        int signed sa, sb_, si;
        sa = a; sb_ = b; si = imm;
        case (o)
            6'd1:  return a + b;
            6'd2:  return a - b;
            6'd3:  return a << b[4:0];
            6'd4:  return (sa < sb_) ? 32'd1 : 32'd0;
            6'd5:  return (a < b) ? 32'd1 : 32'd0;
            6'd6:  return a ^ b;
            6'd7:  return a >> b[4:0];
            6'd8:  return 32'(sa >>> b[4:0]);
            6'd9:  return a | b;
            6'd10: return a & b;
            6'd11: return a + imm;
            6'd12: return (sa < si) ? 32'd1 : 32'd0;
            6'd13: return (a < imm) ? 32'd1 : 32'd0;
            6'd14: return a ^ imm;
            6'd15: return a | imm;
            6'd20: return a & imm;
            6'd21: return a << sh;
            6'd22: return a >> sh;
            6'd23: return 32'(sa >>> sh);
            6'd16: return (a == b) ? 32'd1 : 32'd0;
            6'd17: return (a != b) ? 32'd1 : 32'd0;
            6'd18: return (sa < sb_) ? 32'd1 : 32'd0;
            6'd19: return (sa >= sb_) ? 32'd1 : 32'd0;
            6'd24: return a + imm;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        reset = 0; rs1_n = 0; rs2_n = 0; rd_n = 0; reg_write = 0; op = 0;
        imm_val = 0; shamt = 0; offset = 0; mem_to_reg = 0; sw = 0;
        lui_cntrl = 0; imm_val_lui = 0; jump = 0; return_address = 0;
        beq_c = 0; bneq_c = 0; blt_c = 0; bge_c = 0;
    endtask

    // Push expectations for the current inputs, clock once, advance the model.
    task automatic run_cycle();
        logic [31:0] a, b, res, wb, saddr, ldata;
        logic        one;
        a   = (rs1_n == 0) ? 32'd0 : m_regs[rs1_n];
        b   = (rs2_n == 0) ? 32'd0 : m_regs[rs2_n];
        res = ref_alu(op, a, b, imm_val, shamt);
        one = (res == 32'd1);
        push(0, res, "alu_result");
        push(1, {31'd0, one & beq_c},  "beq");
        push(2, {31'd0, one & bneq_c}, "bneq");
        push(3, {31'd0, one & blt_c},  "blt");
        push(4, {31'd0, one & bge_c},  "bge");
        push(5, {16'd0, m_psc}, "TIM_PSC");
        push(6, {16'd0, m_arr}, "TIM_ARR");
        ldata = m_mem[res % 32];
        if (jump)            wb = return_address;
        else if (lui_cntrl)  wb = imm_val_lui;
        else if (mem_to_reg) wb = ldata;
        else                 wb = res;
        saddr = a + {{20{offset[11]}}, offset};
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_mem[i] = 0; end
            m_psc = 0; m_arr = 0;
        end else begin
            if (reg_write && rd_n != 0) m_regs[rd_n] = wb;
            if (sw) m_mem[saddr % 32] = b;
            if (op == 6'b100001) m_psc = {imm_val[11:0], rs1_n[4:1]};
            if (op == 6'b100011) m_psc = a[15:0];
            if (op == 6'b100010) m_arr = {imm_val[11:0], rs1_n[4:1]};
            if (op == 6'b100100) m_arr = a[15:0];
        end
        #1;
        clear_inputs();
    endtask

    // Monitor: combinational outputs are presented every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sb.pop_front();
                case (e.kind)
                    0: act = alu_result;
                    1: act = {31'd0, beq};
                    2: act = {31'd0, bneq};
                    3: act = {31'd0, blt};
                    4: act = {31'd0, bge};
                    5: act = {16'd0, tim_psc};
                    default: act = {16'd0, tim_arr};
                endcase
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic read_reg(input logic [4:0] r);
        op = 6'd1; rs1_n = r; rs2_n = 0;
        run_cycle();
    endtask

    logic [5:0] ops [28] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                             6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd20, 6'd21, 6'd22, 6'd23,
                             6'd16, 6'd17, 6'd18, 6'd19, 6'd24,
                             6'h21, 6'h22, 6'h23, 6'h24};

    initial begin
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_mem[i] = 0; end
        m_psc = 0; m_arr = 0;
        clear_inputs();

        // Reset state
        for (int i = 0; i < 32; i++) begin
            push(0, 32'd0, "reset_reg_zero");
            read_reg(5'(i));
        end

        // ADDI x1=5, x2=-3
        op = 6'd11; imm_val = 32'd5; rd_n = 1; reg_write = 1; run_cycle();
        op = 6'd11; imm_val = 32'hFFFF_FFFD; rd_n = 2; reg_write = 1; run_cycle();
        op = 6'd1; rs1_n = 1; rs2_n = 2; rd_n = 3; reg_write = 1;
        push(0, 32'd2, "add_5_m3"); run_cycle();
        op = 6'd4; rs1_n = 2; rs2_n = 1; push(0, 32'd1, "slt_m3_5"); run_cycle();
        op = 6'd5; rs1_n = 2; rs2_n = 1; push(0, 32'd0, "sltu_m3_5"); run_cycle();

        // x0 write is dropped
        lui_cntrl = 1; imm_val_lui = 32'hDEAD; rd_n = 0; reg_write = 1; run_cycle();
        op = 6'd1; push(0, 32'd0, "x0_stays_zero"); run_cycle();

        // Store x1 at word 7, load back into x4; store and write-back together
        sw = 1; rs1_n = 0; rs2_n = 1; offset = 12'd7;
        op = 6'd11; imm_val = 32'd9; rd_n = 6; reg_write = 1; run_cycle();
        op = 6'd24; imm_val = 32'd7; mem_to_reg = 1; rd_n = 4; reg_write = 1;
        push(0, 32'd7, "load_addr"); run_cycle();
        op = 6'd1; rs1_n = 4; push(0, 32'd5, "load_x4"); run_cycle();
        op = 6'd1; rs1_n = 6; push(0, 32'd9, "wb_with_store"); run_cycle();

        // Branch flags
        op = 6'd11; imm_val = 32'd5; rd_n = 3; reg_write = 1; run_cycle();
        op = 6'd16; rs1_n = 1; rs2_n = 3; beq_c = 1; push(1, 32'd1, "beq_taken"); run_cycle();
        op = 6'd17; rs1_n = 1; rs2_n = 3; bneq_c = 1; push(2, 32'd0, "bneq_not_taken"); run_cycle();
        op = 6'd18; rs1_n = 2; rs2_n = 1; blt_c = 1; push(3, 32'd1, "blt_taken"); run_cycle();
        op = 6'd18; rs1_n = 2; rs2_n = 1; blt_c = 0; push(3, 32'd0, "blt_unqualified"); run_cycle();

        // Timers, jump
        op = 6'h21; imm_val = 32'hABC; rs1_n = 5; run_cycle();
        push(5, 32'hABC2, "psc_imm"); run_cycle();
        op = 6'h24; rs1_n = 1; run_cycle();
        push(6, 32'h0005, "arr_reg"); run_cycle();
        jump = 1; return_address = 32'h40; lui_cntrl = 1; imm_val_lui = 32'h77;
        rd_n = 5; reg_write = 1; run_cycle();
        op = 6'd1; rs1_n = 5; push(0, 32'h40, "jump_wb"); run_cycle();

        // Randomized instructions
        for (int n = 0; n < 600; n++) begin
            logic [11:0] r12;
            reset = ($urandom_range(0, 99) == 0);
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 27)];
            rs1_n = 5'($urandom); rs2_n = 5'($urandom); rd_n = 5'($urandom);
            reg_write = ($urandom_range(0, 9) < 7);
            r12 = 12'($urandom);
            imm_val = ($urandom_range(0, 3) == 0) ? $urandom : {{20{r12[11]}}, r12};
            shamt = 5'($urandom); offset = 12'($urandom);
            sw = ($urandom_range(0, 3) == 0);
            mem_to_reg = ($urandom_range(0, 3) == 0);
            lui_cntrl = ($urandom_range(0, 7) == 0); imm_val_lui = $urandom;
            jump = ($urandom_range(0, 9) == 0); return_address = $urandom;
            beq_c = 1'($urandom); bneq_c = 1'($urandom);
            blt_c = 1'($urandom); bge_c = 1'($urandom);
            run_cycle();
        end

        // Drain scoreboard
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
